fir_seq_ctrl: RTL and testbench

//  Run controller for one FIR pass, and the initiator side of the sample-address counter interface.
//  - Drives FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka and ile_razy.
//  - Consumes licznik_full as the end-of-pass indication.
//  - Paces each sample step with a valid/ready handshake to the MAC datapath.
//  - Reports done/err to the register block.

---
 rtl/fir_seq_pkg.sv | 28 ++
 rtl/fir_seq_step_cnt.sv | 37 +++
 rtl/fir_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and widths for the FIR pass controller.
// Optional build macro: FIR_SEQ_PERF_CNT_EN (adds the perf_cycles counter to fir_seq_ctrl).
package fir_seq_pkg;

   localparam int PROBKI_W = 14;
   localparam int WSP_W    = 8;
   localparam int RAZY_W   = 15;
   localparam int ADDR_W   = 13;

   // Largest pass the sample-address counter can walk in one go.
   localparam logic [RAZY_W-1:0] MAX_RAZY = RAZY_W'(2 ** ADDR_W);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STEP,
      WAIT,
      DONE
   } fir_seq_state_t;

   function automatic logic [RAZY_W-1:0] calc_ile_razy(
      input logic [PROBKI_W-1:0] probek,
      input logic [WSP_W-1:0]    wsp
   );
      return RAZY_W'(probek) + RAZY_W'(wsp) - RAZY_W'(1);
   endfunction

endpackage

// File: rtl/fir_seq_step_cnt.sv
// Step counter for one FIR pass: counts accepted MAC steps and flags when the target is reached.
module fir_seq_step_cnt
   import fir_seq_pkg::*;
(
   input  logic              clk_b,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              inc,
   input  logic [RAZY_W-1:0] target,
   output logic [RAZY_W-1:0] count,
   output logic              eq_target
);

   logic [RAZY_W-1:0] cnt_q;
   logic [RAZY_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + RAZY_W'(1);
      end
   end

   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count     = cnt_q;
   assign eq_target = (cnt_q == target);

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR pass controller: loads the address counter, paces MAC steps, checks end-of-pass, reports done/err.
// Optional build macro: FIR_SEQ_PERF_CNT_EN adds perf_cycles (cycles spent from LOAD through DONE).
module fir_seq_ctrl
   import fir_seq_pkg::*;
(
   input  logic                clk_b,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [PROBKI_W-1:0] ile_probek,
   input  logic [WSP_W-1:0]    ile_wsp,
   input  logic                licznik_full,
   input  logic                mac_ready,
   output logic [RAZY_W-1:0]   ile_razy,
   output logic                FSM_zapisz_probki,
   output logic                FSM_reset_licznik,
   output logic                FSM_nowa_probka,
   output logic                mac_valid,
   output logic                busy,
   output logic                done,
   output logic                err
`ifdef FIR_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]         perf_cycles
`endif
);

   fir_seq_state_t      state_q, state_d;
   logic [PROBKI_W-1:0] probek_q, probek_d;
   logic [WSP_W-1:0]    wsp_q, wsp_d;
   logic [RAZY_W-1:0]   ile_razy_q, ile_razy_d;
   logic                err_q, err_d;
   logic                aborted_q, aborted_d;

   logic                step_clear;
   logic                step_inc;
   logic [RAZY_W-1:0]   step_cnt;
   logic                step_eq;

   fir_seq_step_cnt u_step_cnt (
      .clk_b     (clk_b),
      .rst_n     (rst_n),
      .clear     (step_clear),
      .inc       (step_inc),
      .target    (ile_razy_q),
      .count     (step_cnt),
      .eq_target (step_eq)
   );

   always_comb begin
      state_d           = state_q;
      probek_d          = probek_q;
      wsp_d             = wsp_q;
      ile_razy_d        = ile_razy_q;
      err_d             = err_q;
      aborted_d         = aborted_q;
      step_clear        = 1'b0;
      step_inc          = 1'b0;
      FSM_zapisz_probki = 1'b0;
      FSM_reset_licznik = 1'b0;
      FSM_nowa_probka   = 1'b0;
      mac_valid         = 1'b0;
      done              = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               probek_d   = ile_probek;
               wsp_d      = ile_wsp;
               ile_razy_d = calc_ile_razy(ile_probek, ile_wsp);
               err_d      = 1'b0;
               aborted_d  = 1'b0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            FSM_zapisz_probki = 1'b1;
            FSM_reset_licznik = 1'b1;
            step_clear        = 1'b1;
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (probek_q == '0 || wsp_q == '0 || ile_razy_q > MAX_RAZY) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = STEP;
            end
         end
         STEP: begin
            mac_valid = 1'b1;
            // Abort takes priority over a handshake landing in the same cycle.
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (mac_ready) begin
               FSM_nowa_probka = 1'b1;
               step_inc        = 1'b1;
               state_d         = WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (licznik_full && step_eq) begin
               state_d = DONE;
            end else if (!licznik_full && step_cnt < ile_razy_q) begin
               state_d = STEP;
            end else begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // An aborted pass reuses this cycle only to re-arm the counter.
            FSM_reset_licznik = 1'b1;
            done              = !aborted_q;
            state_d           = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         probek_q   <= '0;
         wsp_q      <= '0;
         ile_razy_q <= '0;
         err_q      <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         probek_q   <= probek_d;
         wsp_q      <= wsp_d;
         ile_razy_q <= ile_razy_d;
         err_q      <= err_d;
         aborted_q  <= aborted_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign ile_razy = ile_razy_q;
   assign err      = err_q;

`ifdef FIR_SEQ_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == IDLE && start) begin
         perf_d = '0;
      end else if (state_q != IDLE && perf_q != '1) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl paired with a behavioural sample-address counter; randomized passes vs a pass-level model.
module tb_fir_seq_ctrl;
   import fir_seq_pkg::*;

   logic                clk_b = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic [PROBKI_W-1:0] ile_probek = '0;
   logic [WSP_W-1:0]    ile_wsp = '0;
   logic                licznik_full;
   logic                mac_ready = 1'b0;
   logic [RAZY_W-1:0]   ile_razy;
   logic                FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka;
   logic                mac_valid, busy, done, err;
`ifdef FIR_SEQ_PERF_CNT_EN
   logic [31:0]         perf_cycles;
`endif

   fir_seq_ctrl dut (
      .clk_b             (clk_b),
      .rst_n             (rst_n),
      .start             (start),
      .abort             (abort),
      .ile_probek        (ile_probek),
      .ile_wsp           (ile_wsp),
      .licznik_full      (licznik_full),
      .mac_ready         (mac_ready),
      .ile_razy          (ile_razy),
      .FSM_zapisz_probki (FSM_zapisz_probki),
      .FSM_reset_licznik (FSM_reset_licznik),
      .FSM_nowa_probka   (FSM_nowa_probka),
      .mac_valid         (mac_valid),
      .busy              (busy),
      .done              (done),
      .err               (err)
`ifdef FIR_SEQ_PERF_CNT_EN
      ,
      .perf_cycles       (perf_cycles)
`endif
   );

   always #5 clk_b = ~clk_b;

   int cyc = 0;
   always @(posedge clk_b) cyc <= cyc + 1;

   // Sample-address counter the controller drives.
   logic [RAZY_W-1:0] ac_addr, ac_limit;
   logic              ac_full;
   always @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         ac_addr  <= '0;
         ac_limit <= '0;
         ac_full  <= 1'b0;
      end else begin
         if (FSM_zapisz_probki) ac_limit <= ile_razy;
         if (FSM_reset_licznik) begin
            ac_addr <= '0;
            ac_full <= 1'b0;
         end else if (FSM_nowa_probka) begin
            if (ac_addr == ac_limit - RAZY_W'(1)) begin
               ac_addr <= '0;
               ac_full <= 1'b1;
            end else begin
               ac_addr <= ac_addr + RAZY_W'(1);
            end
         end
      end
   end
   assign licznik_full = ac_full;

   int n_tests = 0;
   int n_fail  = 0;
   int stall_plan [64];

   // Observations of the latest pass, in cycles relative to the start cycle.
   int                o_done_cnt, o_done_c, o_end_c, o_valid_cyc, o_zap_cnt, o_rst_cnt;
   int                o_rst_last_c, o_abort_c, o_idle_pulse, o_timeout;
   logic              o_err, o_err_load;
   logic [RAZY_W-1:0] o_razy;
   logic [31:0]       o_perf;
   int                o_addrs [$];

   // Pass-level reference model.
   function automatic logic [RAZY_W-1:0] m_razy(input int p, input int w);
      logic [RAZY_W-1:0] r;
      r = RAZY_W'(p + w - 1);
      return r;
   endfunction
   function automatic bit m_bad(input int p, input int w);
      return (p == 0) || (w == 0) || (p + w - 1 > 8192);
   endfunction
   function automatic int m_latency(input int p, input int w, input int stall_sum);
      return m_bad(p, w) ? 2 : 2 * (p + w - 1) + 2 + stall_sum;
   endfunction

   task automatic run_pass(input int p, input int w, input int abort_at, input int restart_at);
      int k, stall_left, c, sc;
      o_done_cnt = 0; o_done_c = -1; o_end_c = -1; o_valid_cyc = 0; o_zap_cnt = 0;
      o_rst_cnt = 0; o_rst_last_c = -1; o_abort_c = -1; o_idle_pulse = 0; o_timeout = 0;
      o_err = 1'bx; o_err_load = 1'bx; o_razy = 'x; o_perf = '0;
      o_addrs.delete();
      k = 0;
      stall_left = stall_plan[0];
      @(posedge clk_b); #1;
      ile_probek = PROBKI_W'(p);
      ile_wsp    = WSP_W'(w);
      start      = 1'b1;
      sc         = cyc;
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk_b); #1;
         c = cyc - sc;
         start = 1'b0; abort = 1'b0; mac_ready = 1'b0;
         if (c == restart_at) begin
            start = 1'b1; ile_probek = PROBKI_W'(1); ile_wsp = WSP_W'(1);
         end
         if (mac_valid) begin
            if (k == abort_at && o_abort_c < 0) begin
               abort = 1'b1; mac_ready = 1'b1; o_abort_c = c;
            end else if (stall_left > 0) begin
               stall_left--;
            end else begin
               mac_ready = 1'b1;
            end
         end
         @(negedge clk_b);
         if (c == 1) begin
            o_razy = ile_razy;
            o_err_load = err;
         end
         if (mac_valid) o_valid_cyc++;
         if (FSM_nowa_probka) begin
            o_addrs.push_back(int'(ac_addr));
            k++;
            stall_left = (k < 64) ? stall_plan[k] : 0;
         end
         if (FSM_zapisz_probki) o_zap_cnt++;
         if (FSM_reset_licznik) begin
            o_rst_cnt++;
            o_rst_last_c = c;
         end
         if (done) begin
            o_done_cnt++;
            o_done_c = c;
            o_err = err;
         end
         if (!busy && (FSM_zapisz_probki || FSM_reset_licznik || FSM_nowa_probka)) o_idle_pulse++;
         if (!busy) begin
            o_end_c = c;
            break;
         end
      end
      start = 1'b0; abort = 1'b0; mac_ready = 1'b0;
      if (o_end_c < 0) o_timeout = 1;
`ifdef FIR_SEQ_PERF_CNT_EN
      o_perf = perf_cycles;
`endif
      $display("[TB] pass p=%0d w=%0d razy=%0d pulses=%0d done_c=%0d end_c=%0d err=%b", p, w, o_razy, o_addrs.size(), o_done_c, o_end_c, o_err);
   endtask

   task automatic test_reset();
      #2;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_tests++; if (ile_razy !== '0) begin n_fail++; $display("FAIL reset_ile_razy got=%0d exp=0", ile_razy); end
      n_tests++; if ({FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka, mac_valid, done, err} !== 6'b0) begin
         n_fail++; $display("FAIL reset_outputs got=%b exp=000000", {FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka, mac_valid, done, err});
      end
      @(negedge clk_b); @(negedge clk_b);
      rst_n = 1'b1;
      @(negedge clk_b);
      n_tests++; if ({busy, FSM_zapisz_probki, FSM_reset_licznik, done, err} !== 5'b0) begin
         n_fail++; $display("FAIL reset_idle got=%b exp=00000", {busy, FSM_zapisz_probki, FSM_reset_licznik, done, err});
      end
   endtask

   task automatic test_basic();
      foreach (stall_plan[i]) stall_plan[i] = 0;
      run_pass(4, 3, -1, -1);
      n_tests++; if (o_razy !== m_razy(4, 3)) begin n_fail++; $display("FAIL basic_razy got=%0d exp=%0d", o_razy, m_razy(4, 3)); end
      n_tests++; if (o_addrs.size() !== 6) begin n_fail++; $display("FAIL basic_pulses got=%0d exp=6", o_addrs.size()); end
      foreach (o_addrs[i]) begin
         n_tests++; if (o_addrs[i] !== i) begin n_fail++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, o_addrs[i], i); end
      end
      n_tests++; if (o_done_c !== 14) begin n_fail++; $display("FAIL basic_done_latency got=%0d exp=14", o_done_c); end
      n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", o_err); end
      n_tests++; if (o_zap_cnt !== 1 || o_rst_cnt !== 2) begin n_fail++; $display("FAIL basic_ctr_pulses got=%0d/%0d exp=1/2", o_zap_cnt, o_rst_cnt); end
      n_tests++; if (o_idle_pulse !== 0 || o_timeout !== 0) begin n_fail++; $display("FAIL basic_idle_pulse got=%0d/%0d exp=0/0", o_idle_pulse, o_timeout); end
   endtask

   task automatic test_stall();
      foreach (stall_plan[i]) stall_plan[i] = 0;
      stall_plan[1] = 3;
      run_pass(4, 3, -1, -1);
      n_tests++; if (o_addrs.size() !== 6) begin n_fail++; $display("FAIL stall_pulses got=%0d exp=6", o_addrs.size()); end
      n_tests++; if (o_done_c !== 17) begin n_fail++; $display("FAIL stall_done_latency got=%0d exp=17", o_done_c); end
      n_tests++; if (o_valid_cyc !== 9) begin n_fail++; $display("FAIL stall_valid_held got=%0d exp=9", o_valid_cyc); end
      n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL stall_err got=%b exp=0", o_err); end
      stall_plan[1] = 0;
   endtask

   task automatic test_zero_len();
      run_pass(0, 5, -1, -1);
      n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL zero_err got=%b exp=1", o_err); end
      n_tests++; if (o_addrs.size() !== 0 || o_valid_cyc !== 0) begin n_fail++; $display("FAIL zero_steps got=%0d/%0d exp=0/0", o_addrs.size(), o_valid_cyc); end
      n_tests++; if (o_done_c !== 2) begin n_fail++; $display("FAIL zero_done_latency got=%0d exp=2", o_done_c); end
      repeat (3) @(negedge clk_b);
      n_tests++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_err_sticky got=%b%b exp=10", err, done); end
   endtask

   task automatic test_overflow();
      run_pass(8000, 200, -1, -1);
      n_tests++; if (o_razy !== m_razy(8000, 200)) begin n_fail++; $display("FAIL ovf_razy got=%0d exp=%0d", o_razy, m_razy(8000, 200)); end
      n_tests++; if (o_err !== 1'b1 || o_done_c !== 2) begin n_fail++; $display("FAIL ovf_err got=%b@%0d exp=1@2", o_err, o_done_c); end
      n_tests++; if (o_addrs.size() !== 0) begin n_fail++; $display("FAIL ovf_steps got=%0d exp=0", o_addrs.size()); end
      // Exactly the full address range is still a legal pass.
      run_pass(8000, 193, -1, -1);
      n_tests++; if (o_err_load !== 1'b0) begin n_fail++; $display("FAIL edge_err_cleared got=%b exp=0", o_err_load); end
      n_tests++; if (o_err !== 1'b0 || o_done_c !== m_latency(8000, 193, 0)) begin
         n_fail++; $display("FAIL edge_pass got=%b@%0d exp=0@%0d", o_err, o_done_c, m_latency(8000, 193, 0));
      end
      n_tests++; if (o_addrs.size() !== 8192 || o_addrs[$] !== 8191) begin n_fail++; $display("FAIL edge_addrs got=%0d exp=8192", o_addrs.size()); end
   endtask

   task automatic test_abort();
      run_pass(4, 3, 2, -1);
      n_tests++; if (o_addrs.size() !== 2) begin n_fail++; $display("FAIL abort_pulses got=%0d exp=2", o_addrs.size()); end
      n_tests++; if (o_done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", o_done_cnt); end
      n_tests++; if (o_abort_c < 0 || o_rst_last_c !== o_abort_c + 1 || o_end_c !== o_abort_c + 2) begin
         n_fail++; $display("FAIL abort_timing got=abort@%0d rst@%0d idle@%0d exp=rst@+1 idle@+2", o_abort_c, o_rst_last_c, o_end_c);
      end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err got=%b exp=0", err); end
      run_pass(4, 3, -1, -1);
      n_tests++; if (o_addrs.size() !== 6 || o_addrs[0] !== 0 || o_done_c !== 14 || o_err !== 1'b0) begin
         n_fail++; $display("FAIL abort_rerun got=%0d/%0d/%b exp=6/14/0", o_addrs.size(), o_done_c, o_err);
      end
   endtask

   task automatic test_back_to_back();
      run_pass(4, 3, -1, 3);
      n_tests++; if (o_razy !== 6 || ile_razy !== 6) begin n_fail++; $display("FAIL busy_start_razy got=%0d exp=6", ile_razy); end
      n_tests++; if (o_addrs.size() !== 6 || o_done_c !== 14 || o_zap_cnt !== 1) begin
         n_fail++; $display("FAIL busy_start_pass got=%0d/%0d/%0d exp=6/14/1", o_addrs.size(), o_done_c, o_zap_cnt);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         int p, w, ssum, exp_n;
         p = (r % 4 == 3) ? 0 : int'($urandom_range(1, 20));
         w = int'($urandom_range(1, 8));
         ssum = 0;
         foreach (stall_plan[i]) stall_plan[i] = int'($urandom_range(0, 2));
         exp_n = m_bad(p, w) ? 0 : p + w - 1;
         for (int i = 0; i < exp_n; i++) ssum += stall_plan[i];
         run_pass(p, w, -1, -1);
         n_tests++; if (o_razy !== m_razy(p, w)) begin n_fail++; $display("FAIL rnd%0d_razy got=%0d exp=%0d", r, o_razy, m_razy(p, w)); end
         n_tests++; if (o_addrs.size() !== exp_n || o_valid_cyc !== exp_n + ssum) begin
            n_fail++; $display("FAIL rnd%0d_steps got=%0d/%0d exp=%0d/%0d", r, o_addrs.size(), o_valid_cyc, exp_n, exp_n + ssum);
         end
         n_tests++; if (o_done_c !== m_latency(p, w, ssum) || o_err !== m_bad(p, w)) begin
            n_fail++; $display("FAIL rnd%0d_done got=%b@%0d exp=%b@%0d", r, o_err, o_done_c, m_bad(p, w), m_latency(p, w, ssum));
         end
         foreach (o_addrs[i]) begin
            if (o_addrs[i] !== i) begin
               n_tests++; n_fail++; $display("FAIL rnd%0d_addr[%0d] got=%0d exp=%0d", r, i, o_addrs[i], i);
            end
         end
      end
      foreach (stall_plan[i]) stall_plan[i] = 0;
   endtask

   task automatic test_async_reset();
      @(posedge clk_b); #1;
      ile_probek = PROBKI_W'(4); ile_wsp = WSP_W'(3); start = 1'b1; mac_ready = 1'b1;
      @(posedge clk_b); #1; start = 1'b0;
      repeat (3) @(posedge clk_b);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if ({busy, mac_valid, FSM_nowa_probka, FSM_zapisz_probki, FSM_reset_licznik, done, err} !== 7'b0) begin
         n_fail++; $display("FAIL async_rst_outputs got=%b exp=0000000", {busy, mac_valid, FSM_nowa_probka, FSM_zapisz_probki, FSM_reset_licznik, done, err});
      end
      n_tests++; if (ile_razy !== '0) begin n_fail++; $display("FAIL async_rst_razy got=%0d exp=0", ile_razy); end
      mac_ready = 1'b0;
      @(negedge clk_b);
      rst_n = 1'b1;
      run_pass(2, 2, -1, -1);
      n_tests++; if (o_addrs.size() !== 3 || o_done_c !== 8 || o_err !== 1'b0) begin
         n_fail++; $display("FAIL async_rst_rerun got=%0d/%0d/%b exp=3/8/0", o_addrs.size(), o_done_c, o_err);
      end
   endtask

`ifdef FIR_SEQ_PERF_CNT_EN
   task automatic test_perf();
      foreach (stall_plan[i]) stall_plan[i] = 0;
      run_pass(2, 2, -1, -1);
      n_tests++; if (o_perf !== 32'd8) begin n_fail++; $display("FAIL perf_basic got=%0d exp=8", o_perf); end
      repeat (4) @(negedge clk_b);
      n_tests++; if (perf_cycles !== 32'd8) begin n_fail++; $display("FAIL perf_hold got=%0d exp=8", perf_cycles); end
      stall_plan[1] = 3;
      run_pass(4, 3, -1, -1);
      n_tests++; if (o_perf !== 32'd17) begin n_fail++; $display("FAIL perf_stall got=%0d exp=17", o_perf); end
      stall_plan[1] = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_len();
      test_overflow();
      test_abort();
      test_back_to_back();
      test_random();
      test_async_reset();
`ifdef FIR_SEQ_PERF_CNT_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
